// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, a synchronous-read instruction memory
// and a 2-entry buffer, delivering {instr, pc} through a valid/ready handshake.
module fetch_unit #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          instr_ready,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   pc_out,
  output logic [31:0]   pc_plus4,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] tag_q, tag_d;
  logic        inflight_q, inflight_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fifoInstr_q [2];
  logic [31:0] fifoPc_q [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic        tailSlot;
  logic [2:0]  occupancy;
  logic        unusedTargetBits;

  assign unusedTargetBits = ^branch_target[1:0];

  assign instr_valid = (count_q != 2'd0);
  assign instr       = fifoInstr_q[head_q];
  assign pc_out      = fifoPc_q[head_q];
  assign pc_plus4    = pc_out + 32'd4;

  // Occupancy counts the in-flight read so a returning word always finds a free slot.
  assign pop       = instr_valid & instr_ready;
  assign push      = inflight_q & ~branch_taken;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = ~branch_taken & ~prog_we & (occupancy < 3'd2);
  assign tailSlot  = head_q ^ count_q[0];

  always_comb begin
    fetchPc_d  = fetchPc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    head_d     = head_q;
    count_d    = count_q;
    if (branch_taken) begin
      fetchPc_d = {branch_target[31:2], 2'b00};
      head_d    = 1'b0;
      count_d   = 2'd0;
    end else begin
      head_d  = head_q ^ pop;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        fetchPc_d = fetchPc_q + 32'd4;
        tag_d     = fetchPc_q;
      end
    end
  end

  // Memory contents survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
    if (issue) begin
      rdata_q <= mem[fetchPc_q[AW+1:2]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q  <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifoInstr_q[i] <= '0;
        fifoPc_q[i]    <= '0;
      end
    end else begin
      fetchPc_q  <= fetchPc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      count_q    <= count_d;
      if (push) begin
        fifoInstr_q[tailSlot] <= rdata_q;
        fifoPc_q[tailSlot]    <= tag_q;
      end
    end
  end

endmodule
